// File: rtl/pixel_stream_source.sv
// Frame-buffer pixel streamer: walks a bottom-up (BMP-ordered) frame buffer
// top row first, issues one read per pixel, and presents the returned words
// as r/g/b qualified by horizontal_sync, with idle gaps between rows.
module pixel_stream_source #(
  parameter int WIDTH  = 384,
  parameter int HEIGHT = 512,
  parameter int HBLANK = 16,
  parameter int ADDR_W = 18
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              pause,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_data,
  output logic              horizontal_sync,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              busy,
  output logic              done
);

  localparam int COL_W   = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W   = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int BLANK_W = (HBLANK > 1) ? $clog2(HBLANK) : 1;

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(HEIGHT - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'((HBLANK > 0) ? HBLANK - 1 : 0);
  localparam logic [ADDR_W-1:0]  BASE_TOP   = ADDR_W'((HEIGHT - 1) * WIDTH);
  localparam logic [ADDR_W-1:0]  ROW_STEP   = ADDR_W'(WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    BLANK,
    FLUSH,
    DONE
  } state_t;

  state_t              state;
  logic [COL_W-1:0]    col;
  logic [ROW_W-1:0]    row;
  logic [BLANK_W-1:0]  blank_cnt;
  logic                flush_cnt;
  logic [ADDR_W-1:0]   row_base;
  logic                data_valid;

  // Frame sequencer: row_base tracks the buffer address of the current row
  // start, stepping downward because the buffer stores the bottom row first.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      blank_cnt <= '0;
      flush_cnt <= 1'b0;
      row_base  <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      mem_rd <= 1'b0;
      busy   <= (state != IDLE);
      done   <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            state    <= READ;
            col      <= '0;
            row      <= '0;
            row_base <= BASE_TOP;
          end
        end
        READ: begin
          if (!pause) begin
            mem_rd   <= 1'b1;
            mem_addr <= row_base + ADDR_W'(col);
            if (col == COL_LAST) begin
              col <= '0;
              if (row == ROW_LAST) begin
                row       <= '0;
                flush_cnt <= 1'b0;
                state     <= FLUSH;
              end else begin
                row       <= row + 1'b1;
                row_base  <= row_base - ROW_STEP;
                blank_cnt <= '0;
                state     <= (HBLANK > 0) ? BLANK : READ;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        BLANK: begin
          if (blank_cnt == BLANK_LAST) begin
            state <= READ;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
          end
        end
        FLUSH: begin
          if (flush_cnt) begin
            state <= DONE;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Return path: data_valid marks the cycle the memory word is on mem_data,
  // and clearing it on reset drops any read still in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      data_valid      <= 1'b0;
      horizontal_sync <= 1'b0;
      r               <= '0;
      g               <= '0;
      b               <= '0;
    end else begin
      data_valid      <= mem_rd;
      horizontal_sync <= data_valid;
      if (data_valid) begin
        r <= mem_data[23:16];
        g <= mem_data[15:8];
        b <= mem_data[7:0];
      end
    end
  end

endmodule

// File: tb/tb_pixel_stream_source.sv
// Bench for pixel_stream_source: two instances (HBLANK=2 and HBLANK=0) on a
// 4x3 frame, a cycle-indexed expectation table built from the pixel schedule,
// and a few hand-computed literal points.
module tb_pixel_stream_source;

  localparam int W    = 4;
  localparam int H    = 3;
  localparam int AW   = 18;
  localparam int NCYC = 200;
  localparam int HB[2] = '{2, 0};

  logic clock;
  logic reset_s[2];
  logic start_s[2];
  logic pause_s[2];
  logic mem_rd_s[2];
  logic [AW-1:0] addr_s[2];
  logic [23:0] mem_data_s[2];
  logic hs_s[2];
  logic [7:0] r_s[2];
  logic [7:0] g_s[2];
  logic [7:0] b_s[2];
  logic busy_s[2];
  logic done_s[2];

  bit start_at[2][NCYC];
  bit pause_at[2][NCYC];
  bit reset_at[2][NCYC];

  bit exp_rd[2][NCYC];
  bit [AW-1:0] exp_addr[2][NCYC];
  bit exp_hs[2][NCYC];
  bit [23:0] exp_rgb[2][NCYC];
  bit exp_done[2][NCYC];
  bit exp_busy[2][NCYC];

  int cyc = -1;
  int checks = 0;
  int errors = 0;
  int hs_count[2] = '{0, 0};

  pixel_stream_source #(.WIDTH(W), .HEIGHT(H), .HBLANK(2), .ADDR_W(AW)) dut (
    .clock(clock), .reset(reset_s[0]), .start(start_s[0]), .pause(pause_s[0]),
    .mem_rd(mem_rd_s[0]), .mem_addr(addr_s[0]), .mem_data(mem_data_s[0]),
    .horizontal_sync(hs_s[0]), .r(r_s[0]), .g(g_s[0]), .b(b_s[0]),
    .busy(busy_s[0]), .done(done_s[0])
  );

  pixel_stream_source #(.WIDTH(W), .HEIGHT(H), .HBLANK(0), .ADDR_W(AW)) dut_noblank (
    .clock(clock), .reset(reset_s[1]), .start(start_s[1]), .pause(pause_s[1]),
    .mem_rd(mem_rd_s[1]), .mem_addr(addr_s[1]), .mem_data(mem_data_s[1]),
    .horizontal_sync(hs_s[1]), .r(r_s[1]), .g(g_s[1]), .b(b_s[1]),
    .busy(busy_s[1]), .done(done_s[1])
  );

  function automatic logic [23:0] pix(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    return {lo, lo + 8'd1, lo + 8'd2};
  endfunction

  // Free-running clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter: after active edge k, cyc holds k
  always @(posedge clock) cyc <= cyc + 1;

  // Frame-buffer model: one-cycle read latency
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_rd_s[i]) mem_data_s[i] <= pix(addr_s[i]);
    end
  end

  // Schedule one frame whose start is sampled at edge s: one read per pixel in
  // top-row-first order, skipping paused edges, with hb idle cycles between rows.
  task automatic add_frame(input int inst, input int s);
    int t;
    int a;
    int last;
    t = s + 1;
    for (int row = 0; row < H; row++) begin
      for (int col = 0; col < W; col++) begin
        while (pause_at[inst][t]) t++;
        a = (H - 1 - row) * W + col;
        exp_rd[inst][t]       = 1'b1;
        exp_addr[inst][t]     = AW'(a);
        exp_hs[inst][t + 2]   = 1'b1;
        exp_rgb[inst][t + 2]  = pix(AW'(a));
        t++;
      end
      if (row < H - 1) t += HB[inst];
    end
    last = t - 1;
    exp_done[inst][last + 3] = 1'b1;
    for (int c = s + 1; c <= last + 3; c++) exp_busy[inst][c] = 1'b1;
  endtask

  task automatic clear_from(input int inst, input int from);
    for (int c = from; c < NCYC; c++) begin
      exp_rd[inst][c]   = 1'b0;
      exp_addr[inst][c] = '0;
      exp_hs[inst][c]   = 1'b0;
      exp_rgb[inst][c]  = '0;
      exp_done[inst][c] = 1'b0;
      exp_busy[inst][c] = 1'b0;
    end
  endtask

  task automatic build_tables();
    for (int k = 0; k < 4; k++) begin
      reset_at[0][k] = 1'b1;
      reset_at[1][k] = 1'b1;
    end
    start_at[0][10] = 1'b1;
    add_frame(0, 10);
    start_at[0][40] = 1'b1;
    pause_at[0][42] = 1'b1;
    pause_at[0][43] = 1'b1;
    add_frame(0, 40);
    start_at[0][70] = 1'b1;
    add_frame(0, 70);
    reset_at[0][81] = 1'b1;
    clear_from(0, 81);
    start_at[0][90] = 1'b1;
    add_frame(0, 90);
    for (int k = 120; k <= 140; k++) start_at[0][k] = 1'b1;
    add_frame(0, 120);
    add_frame(0, 140);
    start_at[1][10] = 1'b1;
    add_frame(1, 10);
  endtask

  task automatic applyStimulus(input int k);
    for (int i = 0; i < 2; i++) begin
      reset_s[i] = reset_at[i][k];
      start_s[i] = start_at[i][k];
      pause_s[i] = pause_at[i][k];
    end
  endtask

  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s inst%0d cycle %0d: got %0h, expected %0h",
               name, inst, cyc, act, req);
    end
  endtask

  // Per-cycle comparison against the schedule table, plus fixed literal points
  always @(negedge clock) begin
    if (cyc >= 0 && cyc < NCYC) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput("mem_rd", i, 32'(mem_rd_s[i]), 32'(exp_rd[i][cyc]));
        if (exp_rd[i][cyc]) checkOutput("mem_addr", i, 32'(addr_s[i]), 32'(exp_addr[i][cyc]));
        checkOutput("hsync", i, 32'(hs_s[i]), 32'(exp_hs[i][cyc]));
        if (exp_hs[i][cyc]) checkOutput("rgb", i, 32'({r_s[i], g_s[i], b_s[i]}), 32'(exp_rgb[i][cyc]));
        checkOutput("done", i, 32'(done_s[i]), 32'(exp_done[i][cyc]));
        checkOutput("busy", i, 32'(busy_s[i]), 32'(exp_busy[i][cyc]));
        if (hs_s[i] === 1'b1) hs_count[i]++;
      end
      if (cyc == 2) begin
        checkOutput("lit_reset_rgb", 0, 32'({r_s[0], g_s[0], b_s[0]}), 32'h0);
        checkOutput("lit_reset_addr", 0, 32'(addr_s[0]), 32'h0);
      end
      if (cyc == 11) checkOutput("lit_first_addr", 0, 32'(addr_s[0]), 32'd8);
      if (cyc == 13) checkOutput("lit_first_pixel", 0, 32'({r_s[0], g_s[0], b_s[0]}), 32'h08090a);
      if (cyc == 17) checkOutput("lit_row1_addr", 0, 32'(addr_s[0]), 32'd4);
      if (cyc == 29) checkOutput("lit_done_nominal", 0, 32'(done_s[0]), 32'd1);
      if (cyc == 30) checkOutput("lit_idle_busy", 0, 32'(busy_s[0]), 32'd0);
      if (cyc == 42) checkOutput("lit_pause_rd", 0, 32'(mem_rd_s[0]), 32'd0);
      if (cyc == 61) checkOutput("lit_done_pause", 0, 32'(done_s[0]), 32'd1);
      if (cyc == 81) checkOutput("lit_reset_rgb_mid", 0, 32'({r_s[0], g_s[0], b_s[0]}), 32'h0);
      if (cyc == 82) checkOutput("lit_inflight_dropped", 0, 32'(hs_s[0]), 32'd0);
      if (cyc == 91) checkOutput("lit_restart_addr", 0, 32'(addr_s[0]), 32'd8);
      if (cyc == 139) checkOutput("lit_b2b_done", 0, 32'(done_s[0]), 32'd1);
      if (cyc == 141) checkOutput("lit_b2b_addr", 0, 32'(addr_s[0]), 32'd8);
      if (cyc == 22) checkOutput("lit_nb_last_rd", 1, 32'(addr_s[1]), 32'd3);
      if (cyc == 25) checkOutput("lit_nb_done", 1, 32'(done_s[1]), 32'd1);
    end
  end

  initial begin
    build_tables();
    for (int i = 0; i < 2; i++) mem_data_s[i] = '0;
    applyStimulus(0);
    for (int k = 1; k < NCYC - 4; k++) begin
      @(negedge clock);
      applyStimulus(k);
    end
    @(negedge clock);
    #1;
    checkOutput("hsync_total", 0, 32'(hs_count[0]), 32'd66);
    checkOutput("hsync_total", 1, 32'(hs_count[1]), 32'd12);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_stream_source.md
PIXEL_STREAM_SOURCE -- requirements
Module: pixel_stream_source

Interface
REQ-001 SHALL have parameter WIDTH, default 384: pixels per row.
REQ-002 SHALL have parameter HEIGHT, default 512: rows per frame.
REQ-003 SHALL have parameter HBLANK, default 16: idle cycles inserted between rows (0 allowed).
REQ-004 SHALL have parameter ADDR_W, default 18: frame-buffer address width, with WIDTH*HEIGHT <= 2^ADDR_W.
REQ-005 SHALL have port clock, input, 1: the only clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1: frame request, sampled only in IDLE.
REQ-008 SHALL have port pause, input, 1: suppresses new reads while high.
REQ-009 SHALL have port mem_rd, output, 1: frame-buffer read strobe.
REQ-010 SHALL have port mem_addr, output, ADDR_W: pixel word address.
REQ-011 SHALL have port mem_data, input, 24: pixel word, valid exactly one cycle after mem_rd; [23:16]=r, [15:8]=g, [7:0]=b.
REQ-012 SHALL have port horizontal_sync, output, 1: pixel-valid qualifier for r/g/b.
REQ-013 SHALL have ports r, g, b, output, 8 each: pixel components.
REQ-014 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-015 SHALL have port done, output, 1: one-cycle end-of-frame pulse.

Function
REQ-016 SHALL implement states IDLE, READ, BLANK, FLUSH, DONE.
REQ-017 IDLE with start=1 SHALL go to READ next cycle, with row=0 and col=0; start SHALL be ignored in any other state.
REQ-018 In READ with pause=0, SHALL assert mem_rd for one cycle, with mem_addr = (HEIGHT-1-row)*WIDTH + col, so that the bottom-up BMP-ordered buffer streams top row first.
REQ-019 In READ with pause=1, SHALL hold mem_rd=0 and hold col/row; the in-flight read SHALL still be delivered.
REQ-020 After the read of col=WIDTH-1, SHALL set col=0 and increment row, then go to BLANK if HBLANK>0 and rows remain, else to READ if rows remain, else to FLUSH.
REQ-021 BLANK SHALL last exactly HBLANK cycles, independent of pause, then go to READ.
REQ-022 SHALL register mem_data into r/g/b and assert horizontal_sync in the cycle after data arrives, giving a latency of 2 cycles from mem_rd to horizontal_sync.
REQ-023 horizontal_sync SHALL be 0 in every cycle not carrying a pixel; r/g/b SHALL hold their last value when horizontal_sync=0.
REQ-024 FLUSH SHALL last until the final pixel has been presented (2 cycles), then go to DONE.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; a start seen in that cycle SHALL be ignored.
REQ-026 Exactly WIDTH*HEIGHT horizontal_sync pulses SHALL occur per frame, in row-major order.
REQ-027 The col and row counters SHALL wrap only through REQ-020 and SHALL never index beyond WIDTH-1 or HEIGHT-1.

Reset
REQ-028 reset=1 SHALL force IDLE, col=row=0, blank count 0, mem_rd=0, mem_addr=0, horizontal_sync=0, r=g=b=0, busy=0, done=0 at the next edge.
REQ-029 Reset mid-frame SHALL discard any in-flight read: no horizontal_sync is produced after reset and no done pulse follows.
REQ-030 Reset SHALL take priority over start and pause in the same cycle.

Verification (WIDTH=4, HEIGHT=3, HBLANK=2; start sampled at edge 0)
REQ-031 Nominal frame:
- mem_rd at cycles 1-4, 7-10, 13-16; first mem_addr=8, addresses 8..11, 4..7, 0..3.
- horizontal_sync at cycles 3-6, 9-12, 15-18.
- done=1 only at cycle 19; busy=1 from cycles 1-19.
REQ-032 Data path: memory model returns {addr,addr+1,addr+2} as r,g,b -> first pixel r=8, g=9, b=10; the 12 pixels arrive in address order 8..11, 4..7, 0..3.
REQ-033 Pause: pause=1 during cycles 2-3 -> mem_rd low in cycles 2-3, row 0 reads complete at cycle 6, whole schedule shifts by 2, done at cycle 21, still 12 pulses.
REQ-034 Reset at cycle 10 -> horizontal_sync=0 and mem_rd=0 from cycle 11 on, busy=0, no done pulse; a new start then produces a full 12-pixel frame beginning again at address 8.
REQ-035 Start held high continuously -> back-to-back frames; the second frame's first mem_rd occurs at cycle 21, with no overlap with the first frame's done.
REQ-036 HBLANK=0 -> mem_rd continuous for cycles 1-12, horizontal_sync at cycles 3-14, done at cycle 15.
